// File: rtl/key_pkg.sv
// key_pkg: shared debounce constants, channel state type and counter width helper.
package key_pkg;
    localparam int DEBOUNCE_5MS_50MHZ = 250000;
    localparam int DEBOUNCE_SIM = 4;
    typedef enum logic {STABLE, PENDING} key_state_t;
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction
endpackage

// File: rtl/key_conditioner_if.sv
// key_conditioner_if: raw button inputs and conditioned level/strobe outputs.
interface key_conditioner_if #(parameter int N_KEYS = 2);
    logic [N_KEYS-1:0] KEY;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;
    modport master(output KEY, input key_level, key_press, key_release);
    modport slave(input KEY, output key_level, key_press, key_release);
endinterface

// File: rtl/key_debounce.sv
// key_debounce: one button channel - 2-flop synchroniser, stability counter, level and strobes.
module key_debounce
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM
) (
    input  logic clk,
    input  logic rst,
    input  logic pressed_raw,
    output logic level,
    output logic press,
    output logic rel
);
    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic s1, s2;
    logic [CW-1:0] cnt, cnt_n;
    logic level_n, press_n, rel_n, mismatch, done;
    key_state_t st;
    always_comb begin
        st = (cnt == '0) ? STABLE : PENDING;
        mismatch = s2 != level;
        done = mismatch && cnt == LAST;
        // a matching sample or an accepted change both restart the run
        cnt_n = (!mismatch || done) ? '0 : (st == STABLE ? CW'(1) : cnt + CW'(1));
        level_n = done ? s2 : level;
        press_n = done && s2;
        rel_n = done && !s2;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            cnt <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rel <= 1'b0;
        end else begin
            s1 <= pressed_raw;
            s2 <= s1;
            cnt <= cnt_n;
            level <= level_n;
            press <= press_n;
            rel <= rel_n;
        end
    end
endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: per-key polarity normalisation feeding independent debounce channels.
module key_conditioner
    import key_pkg::*;
#(
    parameter int N_KEYS = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_5MS_50MHZ,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input logic CLOCK_50,
    input logic rst,
    key_conditioner_if.slave kif
);
    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk(CLOCK_50),
            .rst(rst),
            .pressed_raw(ACTIVE_LOW ? ~kif.KEY[i] : kif.KEY[i]),
            .level(kif.key_level[i]),
            .press(kif.key_press[i]),
            .rel(kif.key_release[i])
        );
    end
endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed scenarios plus random traffic on an active-high and an active-low instance.
module tb_key_conditioner;
    localparam int D = 4;
    logic CLOCK_50 = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    int np [2][2];
    bit m_lvl [2][2];
    bit m_pr [2][2];
    bit m_rl [2][2];
    int m_run [2][2];
    bit m_dl [2][2][$];
    key_conditioner_if #(.N_KEYS(2)) kif0 ();
    key_conditioner_if #(.N_KEYS(2)) kif1 ();
    key_conditioner #(.N_KEYS(2), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b0)) dut0 (
        .CLOCK_50(CLOCK_50), .rst(rst), .kif(kif0.slave));
    key_conditioner #(.N_KEYS(2), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b1)) dut1 (
        .CLOCK_50(CLOCK_50), .rst(rst), .kif(kif1.slave));
    always #10 CLOCK_50 = ~CLOCK_50;

    // Reference: the level follows a pressed value once D consecutive samples,
    // each taken two clocks after the pin, disagree with the current level.
    task automatic model_edge(input int d, input int c);
        bit raw, samp;
        raw = (d == 0) ? kif0.KEY[c] : ~kif1.KEY[c];
        m_pr[d][c] = 1'b0;
        m_rl[d][c] = 1'b0;
        if (rst) begin
            m_dl[d][c] = {1'b0, 1'b0};
            m_lvl[d][c] = 1'b0;
            m_run[d][c] = 0;
        end else begin
            samp = m_dl[d][c].pop_front();
            m_dl[d][c].push_back(raw);
            m_run[d][c] = (samp != m_lvl[d][c]) ? m_run[d][c] + 1 : 0;
            if (m_run[d][c] == D) begin
                m_lvl[d][c] = samp;
                m_run[d][c] = 0;
                m_pr[d][c] = samp;
                m_rl[d][c] = !samp;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic [1:0] lv, pr, rl;
        @(posedge CLOCK_50);
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 2; c++)
                model_edge(d, c);
        #1;
        for (int d = 0; d < 2; d++) begin
            lv = (d == 0) ? kif0.key_level : kif1.key_level;
            pr = (d == 0) ? kif0.key_press : kif1.key_press;
            rl = (d == 0) ? kif0.key_release : kif1.key_release;
            chk($sformatf("model_level%0d", d), lv, {m_lvl[d][1], m_lvl[d][0]});
            chk($sformatf("model_press%0d", d), pr, {m_pr[d][1], m_pr[d][0]});
            chk($sformatf("model_release%0d", d), rl, {m_rl[d][1], m_rl[d][0]});
            for (int c = 0; c < 2; c++) np[d][c] += int'(pr[c]);
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_np();
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 2; c++) np[d][c] = 0;
    endtask

    initial begin
        bit pat [10] = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1};
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 2; c++) m_dl[d][c] = {1'b0, 1'b0};
        clear_np();
        kif0.KEY = 2'b11;
        kif1.KEY = 2'b11;
        steps(3);
        chk("reset_level", kif0.key_level, 2'b00);
        chk("reset_press", kif0.key_press, 2'b00);
        rst = 1'b0;
        steps(5);
        chk("held_early_press", kif0.key_press, 2'b00);
        step();
        chk("held_press", kif0.key_press, 2'b11);
        chk("held_level", kif0.key_level, 2'b11);
        step();
        chk("held_press_once", kif0.key_press, 2'b00);
        kif0.KEY = 2'b00;
        steps(8);
        kif0.KEY = 2'b10;
        steps(5);
        chk("clean_early", kif0.key_press, 2'b00);
        step();
        chk("clean_press", kif0.key_press, 2'b10);
        chk("clean_level", kif0.key_level, 2'b10);
        steps(14);
        kif0.KEY = 2'b00;
        steps(5);
        chk("clean_rel_early", kif0.key_release, 2'b00);
        step();
        chk("clean_release", kif0.key_release, 2'b10);
        steps(4);
        clear_np();
        kif0.KEY = 2'b01;
        steps(3);
        kif0.KEY = 2'b00;
        steps(10);
        chk("glitch_level", kif0.key_level, 2'b00);
        chk("glitch_strobes", 2'(np[0][0]), 2'd0);
        clear_np();
        for (int i = 0; i < 10; i++) begin
            kif0.KEY[0] = pat[i];
            step();
        end
        chk("bounce_none_yet", 2'(np[0][0]), 2'd0);
        step();
        chk("bounce_press", kif0.key_press, 2'b01);
        steps(10);
        chk("bounce_count", 2'(np[0][0]), 2'd1);
        kif0.KEY = 2'b00;
        steps(8);
        kif0.KEY[0] = 1'b1;
        steps(2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_np();
        steps(5);
        chk("rstmid_no_early", 2'(np[0][0]), 2'd0);
        step();
        chk("rstmid_press", kif0.key_press, 2'b01);
        chk("pol_idle_level", kif1.key_level, 2'b00);
        kif1.KEY = 2'b10;
        steps(5);
        chk("pol_early", kif1.key_press, 2'b00);
        step();
        chk("pol_press", kif1.key_press, 2'b01);
        chk("pol_level", kif1.key_level, 2'b01);
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 5) == 0) kif0.KEY[$urandom_range(0, 1)] ^= 1'b1;
            if ($urandom_range(0, 5) == 0) kif1.KEY[$urandom_range(0, 1)] ^= 1'b1;
            rst = ($urandom_range(0, 149) == 0);
            step();
        end
        rst = 1'b0;
        steps(10);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
